// File: rtl/dma_pingpong_seq_pkg.sv
// Shared types and DMA S2MM register map for the ping/pong capture sequencer.
package dma_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_CR,
        S_WAIT_FREE,
        S_WR_DA,
        S_WR_LEN,
        S_WAIT_IRQ,
        S_CLR_SR,
        S_NOTIFY,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [7:0] OFF_DMACR  = 8'h30;
    localparam logic [7:0] OFF_DMASR  = 8'h34;
    localparam logic [7:0] OFF_DA     = 8'h48;
    localparam logic [7:0] OFF_LENGTH = 8'h58;

    localparam logic [31:0] DMACR_RS         = 32'h0000_0001;
    localparam logic [31:0] DMACR_IOC_IRQ_EN = 32'h0000_1000;
    localparam logic [31:0] DMACR_RUN        = DMACR_RS | DMACR_IOC_IRQ_EN;
    localparam logic [31:0] DMACR_STOP       = 32'h0000_0000;
    localparam logic [31:0] DMASR_IOC        = 32'h0000_1000;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic is_write_state(input state_t s);
        return (s == S_INIT_CR) || (s == S_WR_DA) || (s == S_WR_LEN) ||
               (s == S_CLR_SR)  || (s == S_HALT);
    endfunction

endpackage

// File: rtl/dma_pingpong_seq_axil_single_write.sv
// One-beat AXI4-Lite write engine; req_i is held for the whole write and
// done_o pulses on the B handshake.
module axil_single_write
    import dma_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [31:0]       wdata_o,
    output logic [3:0]        wstrb_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o,
    output logic              done_o,
    output logic              err_o
);

    logic aw_done_q;
    logic w_done_q;

    assign awaddr_o  = addr_i;
    assign wdata_o   = data_i;
    assign wstrb_o   = 4'hF;
    assign awvalid_o = req_i & ~aw_done_q;
    assign wvalid_o  = req_i & ~w_done_q;
    assign bready_o  = req_i & aw_done_q & w_done_q;
    assign done_o    = bready_o & bvalid_i;
    assign err_o     = done_o & (bresp_i != RESP_OKAY);

    // Flags clear on completion so a back-to-back write state starts fresh.
    always_ff @(posedge clk_i) begin
        if (rst_i || !req_i || done_o) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (awvalid_o && awready_i) aw_done_q <= 1'b1;
            if (wvalid_o && wready_i)   w_done_q  <= 1'b1;
        end
    end

endmodule

// File: rtl/dma_pingpong_seq.sv
// Ping/pong S2MM DMA sequencer. Optional WAIT_IRQ watchdog: DMA_SEQ_TIMEOUT_EN.
// state     | meaning
// IDLE      | stopped, waiting for start
// INIT_CR   | writing DMACR run + IOC irq enable
// WAIT_FREE | waiting for consumer to free the next buffer
// WR_DA     | writing destination address
// WR_LEN    | writing LENGTH, which launches the transfer
// WAIT_IRQ  | waiting for completion interrupt
// CLR_SR    | clearing IOC in DMASR
// NOTIFY    | one-cycle buffer hand-off
// HALT      | writing DMACR = 0 before returning to IDLE
// ERR       | bad write response or timeout; wait for start
module dma_pingpong_seq
    import dma_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 26
) (
    input  logic              aclk_i,
    input  logic              areset_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [ADDR_W-1:0] cfg_base_i,
    input  logic [31:0]       cfg_ping_i,
    input  logic [31:0]       cfg_pong_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    output logic [ADDR_W-1:0] m_awaddr_o,
    output logic              m_awvalid_o,
    input  logic              m_awready_i,
    output logic [31:0]       m_wdata_o,
    output logic [3:0]        m_wstrb_o,
    output logic              m_wvalid_o,
    input  logic              m_wready_i,
    input  logic [1:0]        m_bresp_i,
    input  logic              m_bvalid_i,
    output logic              m_bready_o,
    input  logic              dma_irq_i,
    output logic              buf_ready_o,
    output logic              buf_idx_o,
    input  logic              buf_release_i,
    input  logic              buf_release_idx_i,
    output logic              busy_o,
    output logic              error_o
);

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       ping_q;
    logic [31:0]       pong_q;
    logic [LEN_W-1:0]  len_q;
    logic              next_q;
    logic [1:0]        owned_q;
    logic [1:0]        owned_d;
    logic [1:0]        rel_mask;
    logic [1:0]        set_mask;
    logic              stop_q;
    logic              error_q;
    logic              buf_ready_q;
    logic              buf_idx_q;
    logic              wr_req;
    logic              wr_done;
    logic              wr_err;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
`ifdef DMA_SEQ_TIMEOUT_EN
    logic [23:0]       tmo_q;
`endif

    assign busy_o      = (state_q != S_IDLE);
    assign error_o     = error_q;
    assign buf_ready_o = buf_ready_q;
    assign buf_idx_o   = buf_idx_q;
    assign wr_req      = is_write_state(state_q);

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            S_INIT_CR: begin wr_addr = base_q + ADDR_W'(OFF_DMACR);  wr_data = DMACR_RUN;  end
            S_WR_DA:   begin wr_addr = base_q + ADDR_W'(OFF_DA);     wr_data = next_q ? pong_q : ping_q; end
            S_WR_LEN:  begin wr_addr = base_q + ADDR_W'(OFF_LENGTH); wr_data = 32'(len_q); end
            S_CLR_SR:  begin wr_addr = base_q + ADDR_W'(OFF_DMASR);  wr_data = DMASR_IOC;  end
            S_HALT:    begin wr_addr = base_q + ADDR_W'(OFF_DMACR);  wr_data = DMACR_STOP; end
            default:   begin wr_addr = '0; wr_data = '0; end
        endcase
    end

    // A release and a NOTIFY on the other buffer in the same cycle both land.
    always_comb begin
        rel_mask = buf_release_i ? (2'b01 << buf_release_idx_i) : 2'b00;
        set_mask = (state_q == S_NOTIFY) ? (2'b01 << next_q) : 2'b00;
        owned_d  = (owned_q & ~rel_mask) | set_mask;
    end

    axil_single_write #(.ADDR_W(ADDR_W)) u_wr (
        .clk_i     (aclk_i),
        .rst_i     (areset_i),
        .req_i     (wr_req),
        .addr_i    (wr_addr),
        .data_i    (wr_data),
        .awaddr_o  (m_awaddr_o),
        .awvalid_o (m_awvalid_o),
        .awready_i (m_awready_i),
        .wdata_o   (m_wdata_o),
        .wstrb_o   (m_wstrb_o),
        .wvalid_o  (m_wvalid_o),
        .wready_i  (m_wready_i),
        .bresp_i   (m_bresp_i),
        .bvalid_i  (m_bvalid_i),
        .bready_o  (m_bready_o),
        .done_o    (wr_done),
        .err_o     (wr_err)
    );

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            ping_q      <= '0;
            pong_q      <= '0;
            len_q       <= '0;
            next_q      <= 1'b0;
            owned_q     <= 2'b00;
            stop_q      <= 1'b0;
            error_q     <= 1'b0;
            buf_ready_q <= 1'b0;
            buf_idx_q   <= 1'b0;
`ifdef DMA_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            buf_ready_q <= 1'b0;
            owned_q     <= owned_d;
            if (stop_i && state_q != S_IDLE) stop_q <= 1'b1;
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start_i) begin
                        base_q  <= cfg_base_i;
                        ping_q  <= cfg_ping_i;
                        pong_q  <= cfg_pong_i;
                        len_q   <= cfg_len_i;
                        next_q  <= 1'b0;
                        owned_q <= 2'b00;
                        stop_q  <= 1'b0;
                        error_q <= 1'b0;
                        state_q <= S_INIT_CR;
                    end
                end
                S_WAIT_FREE: begin
                    if (stop_q)                state_q <= S_HALT;
                    else if (!owned_q[next_q]) state_q <= S_WR_DA;
                end
                S_WAIT_IRQ: begin
                    if (dma_irq_i) begin
                        state_q <= S_CLR_SR;
`ifdef DMA_SEQ_TIMEOUT_EN
                    end else if (tmo_q == '0) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
`endif
                    end
                end
                S_NOTIFY: begin
                    next_q  <= ~next_q;
                    state_q <= S_WAIT_FREE;
                end
                default: begin
                    if (wr_done) begin
                        if (wr_err) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else begin
                            case (state_q)
                                S_INIT_CR: state_q <= S_WAIT_FREE;
                                S_WR_DA:   state_q <= S_WR_LEN;
                                S_WR_LEN: begin
                                    state_q <= S_WAIT_IRQ;
`ifdef DMA_SEQ_TIMEOUT_EN
                                    tmo_q   <= 24'hFF_FFFF;
`endif
                                end
                                S_CLR_SR: begin
                                    state_q     <= S_NOTIFY;
                                    buf_ready_q <= 1'b1;
                                    buf_idx_q   <= next_q;
                                end
                                default: begin
                                    state_q <= S_IDLE;
                                    stop_q  <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_pingpong_seq.sv
// Scoreboard bench: expected AXI writes and buffer hand-offs are queued as
// stimulus is applied and matched against what the sequencer emits.
module tb_dma_pingpong_seq;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        areset, start, stop;
    logic [31:0] cfg_base, cfg_ping, cfg_pong;
    logic [25:0] cfg_len;
    logic [31:0] m_awaddr, m_wdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready;
    logic        dma_irq, buf_ready, buf_idx, buf_release, buf_release_idx;
    logic        busy, error;

    wr_t         exp_q[$];
    bit          buf_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          aw_count = 0;
    logic        stall = 1'b0;
    logic        err_armed = 1'b0;
    logic [31:0] err_addr = '0;
    logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0;
    logic [31:0] cap_addr, cap_data;
    logic [1:0]  b_resp_pend = 2'b00;

    always #5 clk = ~clk;

    dma_pingpong_seq dut (
        .aclk_i            (clk),
        .areset_i          (areset),
        .start_i           (start),
        .stop_i            (stop),
        .cfg_base_i        (cfg_base),
        .cfg_ping_i        (cfg_ping),
        .cfg_pong_i        (cfg_pong),
        .cfg_len_i         (cfg_len),
        .m_awaddr_o        (m_awaddr),
        .m_awvalid_o       (m_awvalid),
        .m_awready_i       (m_awready),
        .m_wdata_o         (m_wdata),
        .m_wstrb_o         (m_wstrb),
        .m_wvalid_o        (m_wvalid),
        .m_wready_i        (m_wready),
        .m_bresp_i         (m_bresp),
        .m_bvalid_i        (m_bvalid),
        .m_bready_o        (m_bready),
        .dma_irq_i         (dma_irq),
        .buf_ready_o       (buf_ready),
        .buf_idx_o         (buf_idx),
        .buf_release_i     (buf_release),
        .buf_release_idx_i (buf_release_idx),
        .busy_o            (busy),
        .error_o           (error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Wait until every queued write has completed its B phase, then settle.
    task automatic drain(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || b_pend || aw_got || w_got) && t < 500) begin
            tick();
            t++;
        end
        chk({tag, "_drained"}, 64'(t < 500), 1);
        tick();
        tick();
    endtask

    task automatic pulse_irq();
        dma_irq = 1'b1;
        tick();
        dma_irq = 1'b0;
    endtask

    // AXI slave and output monitor; decisions at negedge apply to the next posedge.
    initial begin
        wr_t e;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (areset) begin
                m_awready = 1'b0;
                m_wready  = 1'b0;
                m_bvalid  = 1'b0;
                m_bresp   = 2'b00;
                aw_got    = 1'b0;
                w_got     = 1'b0;
                b_pend    = 1'b0;
            end else begin
                m_awready = !stall && ($urandom_range(0, 3) != 0);
                m_wready  = !stall && ($urandom_range(0, 3) != 0);
                m_bvalid  = b_pend;
                m_bresp   = b_pend ? b_resp_pend : 2'b00;
                if (m_bvalid && m_bready) b_pend = 1'b0;
                if (m_awvalid && m_awready) begin
                    cap_addr = m_awaddr;
                    aw_got   = 1'b1;
                    aw_count++;
                end
                if (m_wvalid && m_wready) begin
                    cap_data = m_wdata;
                    w_got    = 1'b1;
                    chk("wstrb", 64'(m_wstrb), 64'hF);
                end
                if (aw_got && w_got) begin
                    chk("aw_expected", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("awaddr", 64'(cap_addr), 64'(e.addr));
                        chk("wdata", 64'(cap_data), 64'(e.data));
                    end
                    if (err_armed && cap_addr == err_addr) begin
                        b_resp_pend = 2'b10;
                        err_armed   = 1'b0;
                    end else begin
                        b_resp_pend = 2'b00;
                    end
                    b_pend = 1'b1;
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                end
                if (buf_ready) begin
                    chk("buf_expected", 64'(buf_q.size() != 0), 1);
                    if (buf_q.size() != 0) chk("buf_idx", 64'(buf_idx), 64'(buf_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int c;
        areset = 1'b1; start = 1'b0; stop = 1'b0; dma_irq = 1'b0;
        buf_release = 1'b0; buf_release_idx = 1'b0;
        cfg_base = 32'h4000_0000; cfg_ping = 32'hC000_0000;
        cfg_pong = 32'hC000_4000; cfg_len = 26'h4000;
        repeat (3) tick();
        chk("rst_awvalid", 64'(m_awvalid), 0);
        chk("rst_wvalid", 64'(m_wvalid), 0);
        chk("rst_bready", 64'(m_bready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_error", 64'(error), 0);
        chk("rst_buf_ready", 64'(buf_ready), 0);
        areset = 1'b0;
        tick();

        // Start: DMACR, DA(ping), LENGTH.
        push_wr(32'h4000_0030, 32'h0000_1001);
        push_wr(32'h4000_0048, 32'hC000_0000);
        push_wr(32'h4000_0058, 32'h0000_4000);
        start = 1'b1; tick(); start = 1'b0;
        chk("busy_after_start", 64'(busy), 1);
        drain("start");

        // First completion: DMASR clear, ping hand-off, then pong programmed.
        push_wr(32'h4000_0034, 32'h0000_1000);
        buf_q.push_back(1'b0);
        push_wr(32'h4000_0048, 32'hC000_4000);
        push_wr(32'h4000_0058, 32'h0000_4000);
        dma_irq = 1'b1; tick(); dma_irq = 1'b0;
        t = 1;
        while (!buf_ready && t < 200) begin tick(); t++; end
        chk("irq_to_buf_ge3", 64'(t >= 3 && t < 200), 1);
        drain("ping1");

        // Second completion with nothing released: sequencer must stall.
        push_wr(32'h4000_0034, 32'h0000_1000);
        buf_q.push_back(1'b1);
        pulse_irq();
        drain("pong1");
        c = aw_count;
        repeat (20) tick();
        chk("blocked_no_aw", 64'(aw_count - c), 0);
        chk("blocked_awvalid", 64'(m_awvalid), 0);
        chk("blocked_busy", 64'(busy), 1);

        // Releasing ping restarts DA exactly two edges later.
        push_wr(32'h4000_0048, 32'hC000_0000);
        push_wr(32'h4000_0058, 32'h0000_4000);
        buf_release = 1'b1; buf_release_idx = 1'b0;
        tick();
        buf_release = 1'b0;
        t = 1;
        while (!m_awvalid && t < 50) begin tick(); t++; end
        chk("release_to_da", 64'(t), 2);
        drain("ping2");

        // Complete ping, release pong, fail the DA write.
        push_wr(32'h4000_0034, 32'h0000_1000);
        buf_q.push_back(1'b0);
        pulse_irq();
        drain("ping2_done");
        err_addr = 32'h4000_0048; err_armed = 1'b1;
        push_wr(32'h4000_0048, 32'hC000_4000);
        buf_release = 1'b1; buf_release_idx = 1'b1;
        tick();
        buf_release = 1'b0;
        drain("err_da");
        chk("err_error", 64'(error), 1);
        chk("err_busy", 64'(busy), 1);
        c = aw_count;
        repeat (10) tick();
        chk("err_no_aw", 64'(aw_count - c), 0);

        // Restart from ERR: fresh ping order, error cleared.
        push_wr(32'h4000_0030, 32'h0000_1001);
        push_wr(32'h4000_0048, 32'hC000_0000);
        push_wr(32'h4000_0058, 32'h0000_4000);
        start = 1'b1; tick(); start = 1'b0;
        chk("err_cleared", 64'(error), 0);
        drain("restart");

        // Stop in WAIT_IRQ: finish the buffer, then DMACR=0 and back to IDLE.
        stop = 1'b1; tick(); stop = 1'b0;
        push_wr(32'h4000_0034, 32'h0000_1000);
        buf_q.push_back(1'b0);
        push_wr(32'h4000_0030, 32'h0000_0000);
        pulse_irq();
        t = 0;
        while (busy && t < 500) begin tick(); t++; end
        chk("halt_busy", 64'(busy), 0);
        chk("halt_error", 64'(error), 0);
        tick();

        // Reset while a write is stalled on AW/W.
        stall = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        t = 0;
        while (!m_awvalid && t < 20) begin tick(); t++; end
        chk("midwr_awvalid_seen", 64'(m_awvalid), 1);
        areset = 1'b1;
        tick();
        chk("midrst_awvalid", 64'(m_awvalid), 0);
        chk("midrst_wvalid", 64'(m_wvalid), 0);
        chk("midrst_bready", 64'(m_bready), 0);
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_error", 64'(error), 0);
        chk("midrst_buf_ready", 64'(buf_ready), 0);
        areset = 1'b0;
        stall  = 1'b0;
        tick();

        chk("exp_q_empty", 64'(exp_q.size()), 0);
        chk("buf_q_empty", 64'(buf_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
